// File: rtl/note_plotter_pkg.sv
// Shared constants, types and geometry helpers for the note grid plotter.
package note_plotter_pkg;

   localparam int NUM_LANES       = 5;
   localparam int NUM_ROWS        = 8;
   localparam int NOTE_W          = 16;
   localparam int NOTE_H          = 8;
   localparam int LANE_PITCH      = 32;
   localparam int ROW_PITCH       = 15;
   localparam int X_OFFSET        = 8;
   localparam int PX_W            = 4;
   localparam int PY_W            = 3;
   localparam int PIXELS_PER_NOTE = NOTE_W * NOTE_H;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_SCAN  = 2'b01,
      ST_PIXEL = 2'b10,
      ST_DONE  = 2'b11
   } plot_state_t;

   typedef enum logic {
      MODE_DRAW  = 1'b0,
      MODE_ERASE = 1'b1
   } plot_mode_t;

   typedef logic [NUM_LANES-1:0] lane_row_t;
   typedef lane_row_t [NUM_ROWS-1:0] note_grid_t;

   function automatic logic [2:0] lane_colour(input logic [2:0] lane);
      logic [2:0] c;
      case (lane)
         3'd0:    c = 3'b010;
         3'd1:    c = 3'b100;
         3'd2:    c = 3'b110;
         3'd3:    c = 3'b001;
         3'd4:    c = 3'b101;
         default: c = 3'b000;
      endcase
      return c;
   endfunction

   function automatic logic [7:0] cell_origin_x(input logic [2:0] lane);
      return 8'(X_OFFSET + LANE_PITCH * int'(lane));
   endfunction

   function automatic logic [6:0] cell_origin_y(input logic [2:0] row);
      return 7'(ROW_PITCH * int'(row));
   endfunction

endpackage

// File: rtl/note_plotter_if.sv
// Control/VGA bundle between the game control FSM and the note plotter.
interface note_plotter_if;
   import note_plotter_pkg::*;

   logic            FSM_shift;
   logic            FSM_plot;
   logic            FSM_clear;
   lane_row_t       new_row;
   logic [7:0]      x_out;
   logic [6:0]      y_out;
   logic [2:0]      colour;
   logic            plot_en;
   logic            printed_register;
   lane_row_t       bottom_row;

   modport master (
      output FSM_shift, FSM_plot, FSM_clear, new_row,
      input  x_out, y_out, colour, plot_en, printed_register, bottom_row
   );

   modport slave (
      input  FSM_shift, FSM_plot, FSM_clear, new_row,
      output x_out, y_out, colour, plot_en, printed_register, bottom_row
   );

endinterface

// File: rtl/note_pixel_counter.sv
// Walks the 16x8 pixels of one note box, px fastest; flags the last pixel.
module note_pixel_counter
   import note_plotter_pkg::*;
(
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   output logic [PX_W-1:0] px,
   output logic [PY_W-1:0] py,
   output logic            done
);

   logic [PX_W+PY_W-1:0] count_r;

   // Pixel index: advances while enabled, held at zero otherwise so each box starts at (0,0)
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         count_r <= '0;
      end else if (en) begin
         count_r <= count_r + 7'd1;
      end else begin
         count_r <= '0;
      end
   end

   assign px   = count_r[PX_W-1:0];
   assign py   = count_r[PX_W+PY_W-1:PX_W];
   assign done = (count_r == 7'(PIXELS_PER_NOTE - 1));

endmodule

// File: rtl/note_plotter.sv
// Note grid plotter: holds the 8x5 note grid, shifts it on request and streams
// note-box pixels to the VGA writer for draw or erase passes.
module note_plotter
   import note_plotter_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   note_plotter_if.slave bus
);

   plot_state_t     state_r;
   plot_state_t     next_state_s;
   plot_mode_t      mode_r;
   note_grid_t      grid_r;
   note_grid_t      snap_r;
   lane_row_t       bottom_row_r;
   logic [2:0]      row_r;
   logic [2:0]      lane_r;

   logic            start_s;
   logic            cell_hit_s;
   logic            last_cell_s;
   logic            pix_en_s;
   logic            pix_done_s;
   logic            advance_s;
   logic [PX_W-1:0] px_s;
   logic [PY_W-1:0] py_s;

   logic [7:0]      x_r;
   logic [6:0]      y_r;
   logic [2:0]      colour_r;
   logic            plot_en_r;
   logic            printed_r;
   logic            in_done_r;

   note_pixel_counter u_pixel_counter (
      .clk   (clk),
      .reset (reset),
      .en    (pix_en_s),
      .px    (px_s),
      .py    (py_s),
      .done  (pix_done_s)
   );

   // Scan-position decode shared by the FSM and the datapath
   always_comb begin
      start_s     = (state_r == ST_IDLE) && (bus.FSM_plot || bus.FSM_clear);
      cell_hit_s  = snap_r[row_r][lane_r];
      last_cell_s = (row_r == 3'(NUM_ROWS - 1)) && (lane_r == 3'(NUM_LANES - 1));
      pix_en_s    = (state_r == ST_PIXEL);
      advance_s   = ((state_r == ST_SCAN) && !cell_hit_s) || (pix_en_s && pix_done_s);
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= next_state_s;
      end
   end

   // Next-state logic; DONE waits for both requests to drop so a held request cannot re-scan
   always_comb begin
      next_state_s = state_r;
      case (state_r)
         ST_IDLE: begin
            if (start_s) next_state_s = ST_SCAN;
            else         next_state_s = ST_IDLE;
         end
         ST_SCAN: begin
            if (cell_hit_s)       next_state_s = ST_PIXEL;
            else if (last_cell_s) next_state_s = ST_DONE;
            else                  next_state_s = ST_SCAN;
         end
         ST_PIXEL: begin
            if (!pix_done_s)      next_state_s = ST_PIXEL;
            else if (last_cell_s) next_state_s = ST_DONE;
            else                  next_state_s = ST_SCAN;
         end
         ST_DONE: begin
            if (!bus.FSM_plot && !bus.FSM_clear) next_state_s = ST_IDLE;
            else                                 next_state_s = ST_DONE;
         end
         default: next_state_s = ST_IDLE;
      endcase
   end

   // Grid, snapshot and scan position; the scan reads a snapshot so a same-cycle shift sees the old grid
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grid_r       <= '0;
         snap_r       <= '0;
         bottom_row_r <= '0;
         mode_r       <= MODE_DRAW;
         row_r        <= 3'd0;
         lane_r       <= 3'd0;
      end else begin
         if (start_s) begin
            snap_r <= grid_r;
            mode_r <= bus.FSM_plot ? MODE_DRAW : MODE_ERASE;
            row_r  <= 3'd0;
            lane_r <= 3'd0;
         end else if (advance_s) begin
            if (lane_r == 3'(NUM_LANES - 1)) begin
               lane_r <= 3'd0;
               row_r  <= row_r + 3'd1;
            end else begin
               lane_r <= lane_r + 3'd1;
            end
         end
         if ((state_r == ST_IDLE) && bus.FSM_shift) begin
            bottom_row_r <= grid_r[NUM_ROWS-1];
            grid_r       <= {grid_r[NUM_ROWS-2:0], bus.new_row};
         end
      end
   end

   // Registered outputs, each trailing the state that produces it by one cycle
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         x_r       <= 8'd0;
         y_r       <= 7'd0;
         colour_r  <= 3'b000;
         plot_en_r <= 1'b0;
         printed_r <= 1'b0;
         in_done_r <= 1'b0;
      end else begin
         plot_en_r <= pix_en_s;
         in_done_r <= (state_r == ST_DONE);
         printed_r <= (state_r == ST_DONE) && !in_done_r;
         if (pix_en_s) begin
            x_r      <= cell_origin_x(lane_r) + {4'd0, px_s};
            y_r      <= cell_origin_y(row_r) + {4'd0, py_s};
            colour_r <= (mode_r == MODE_DRAW) ? lane_colour(lane_r) : 3'b000;
         end
      end
   end

   assign bus.x_out            = x_r;
   assign bus.y_out            = y_r;
   assign bus.colour           = colour_r;
   assign bus.plot_en          = plot_en_r;
   assign bus.printed_register = printed_r;
   assign bus.bottom_row       = bottom_row_r;

endmodule

// File: doc/note_plotter.md
NOTE_PLOTTER -- requirements
Module: note_plotter

Interface
REQ-001 clk  in  1  system clock; all state changes on rising edge.
REQ-002 reset  in  1  asynchronous, active-low; asserted (0) forces all state and outputs to reset values immediately.
REQ-003 FSM_shift  in  1  one-cycle request to shift the note grid down one row.
REQ-004 FSM_plot  in  1  level request to draw the grid; held until printed_register seen.
REQ-005 FSM_clear  in  1  level request to erase the grid; held until printed_register seen.
REQ-006 new_row  in  5  lane bits loaded into row 0 on shift (bit i = lane i).
REQ-007 x_out  out  8  pixel X, 0..159.
REQ-008 y_out  out  7  pixel Y, 0..119.
REQ-009 colour  out  3  pixel colour, RGB 1-bit each.
REQ-010 plot_en  out  1  VGA write strobe; x_out/y_out/colour valid when 1.
REQ-011 printed_register  out  1  one-cycle pulse: grid fully drawn or erased.
REQ-012 bottom_row  out  5  row that fell off row 7 on the last shift (hit window).

Function
REQ-013 Grid: 8 rows x 5 lanes, 40 bits; row 0 top, row 7 bottom.
REQ-014 Cell geometry: cell (r,l) origin x = 8 + 32*l, y = 15*r; note box 16 wide x 8 tall.
REQ-015 States: IDLE, SCAN, PIXEL, DONE; reset state IDLE.
REQ-016 IDLE: FSM_plot=1 -> SCAN, mode DRAW; else FSM_clear=1 -> SCAN, mode ERASE; both high -> DRAW wins.
REQ-017 IDLE: FSM_shift=1 -> bottom_row <= row 7, row r+1 <= row r, row 0 <= new_row, in one cycle.
REQ-018 FSM_shift outside IDLE ignored; grid unchanged.
REQ-019 Shift and plot/clear in the same IDLE cycle: shift applies; scan starts on the same edge using the pre-shift grid.
REQ-020 SCAN: visits cells row-major (r 0..7, l 0..4), one cycle per cell; bit 0 -> next cell; bit 1 -> PIXEL.
REQ-021 PIXEL: 128 cycles, plot_en=1 each, px 0..15 inner, py 0..7 outer; x_out = origin_x+px, y_out = origin_y+py; then next cell in SCAN.
REQ-022 colour: DRAW -> lane colour from package table; ERASE -> 3'b000.
REQ-023 After cell (7,4) completes -> DONE; printed_register=1 in the first DONE cycle only.
REQ-024 DONE -> IDLE only when FSM_plot=0 and FSM_clear=0; no re-scan while request held.
REQ-025 Latency, empty grid: printed_register high exactly 41 cycles after the edge sampling FSM_plot=1.
REQ-026 Latency, N occupied cells: 41 + 128*N cycles.
REQ-027 plot_en=0 in IDLE, SCAN, DONE.
REQ-028 Request dropped mid-scan: scan continues to DONE (no abort).
REQ-029 Coordinate arithmetic never exceeds 159/119; no wrap needed.

Reset
REQ-030 On reset=0: state IDLE, grid 0, bottom_row 0, x_out 0, y_out 0, colour 0, plot_en 0, printed_register 0.
REQ-031 Reset mid-PIXEL: plot_en drops asynchronously; no further writes; next request starts a fresh scan.

Structure
REQ-032 Shared package: NUM_LANES=5, NUM_ROWS=8, NOTE_W=16, NOTE_H=8, LANE_PITCH=32, ROW_PITCH=15, X_OFFSET=8, lane colour table, state encoding.
REQ-033 One sub-module natural: note_pixel_counter (px/py counter, 128-count, done flag).
REQ-034 Outputs registered; printed_register compatible with existing control FSM DRAW->WAIT and ERASE->DEC_REG transitions.

Verification
REQ-035 Empty grid, FSM_plot held -> 0 plot_en pulses, printed_register single pulse at cycle 41, returns IDLE after FSM_plot=0.
REQ-036 Shift new_row=5'b00001, then plot -> 128 writes, x 8..23, y 0..7, lane-0 colour, pulse at cycle 169.
REQ-037 Eight shifts of 5'b10000 then shift 0 -> bottom_row=5'b10000; grid rows 0 = 0, rows 1..7 = 5'b10000.
REQ-038 Plot then clear same grid -> identical coordinate sequences, clear colour 000.
REQ-039 FSM_plot and FSM_clear both high -> DRAW colours; FSM_shift during SCAN -> grid unchanged.
REQ-040 reset=0 mid-PIXEL -> plot_en 0 same cycle, all outputs at reset values, grid 0.
